core_fetch: RTL
===============

CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-low.
REQ-004 FETCH_EN  in  1  core permits new fetches.
REQ-005 MEM_REQ  out  1  one-cycle instruction-read request.
REQ-006 MEM_ADDR  out  32  fetch address, equal to internal pc at all times.
REQ-007 MEM_VALID  in  1  read data valid; earliest one cycle after MEM_REQ; one pulse per request.
REQ-008 MEM_DATA  in  32  instruction word, sampled only when MEM_VALID=1.
REQ-009 INST_VALID  out  1  INST/INST_PC hold a fetched instruction for decode.
REQ-010 INST_READY  in  1  decode accepts the instruction.
REQ-011 INST  out  32  fetched instruction word.
REQ-012 INST_PC  out  32  address INST was fetched from.
REQ-013 REDIRECT  in  1  branch/jump taken; flushes fetch.
REQ-014 REDIRECT_PC  in  32  redirect target.
REQ-015 EXC_MISALIGN  out  1  misaligned redirect target fault.
REQ-016 EXC_PC  out  32  faulting target address.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN, FAULT; one-hot encoding.
REQ-018 IDLE: MEM_REQ=0; FETCH_EN=1 -> REQ next cycle; MEM_VALID ignored.
REQ-019 REQ: MEM_REQ=1 for exactly one cycle; outstanding flag set; -> WAIT.
REQ-020 WAIT: on MEM_VALID capture INST<=MEM_DATA, INST_PC<=pc, INST_VALID<=1, clear outstanding, -> HOLD.
REQ-021 HOLD: INST, INST_PC, INST_VALID held stable until INST_VALID&INST_READY.
REQ-022 Transfer in HOLD: pc<=pc+4, INST_VALID<=0, -> REQ if FETCH_EN=1 else IDLE; minimum 3 cycles per instruction with single-cycle memory.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-024 FETCH_EN deassertion SHALL NOT abort an in-flight fetch; block stops only after the HOLD transfer.
REQ-025 REDIRECT in any state has priority over every other event: pc<=REDIRECT_PC, INST_VALID<=0; a simultaneous INST_READY transfer is void.
REQ-026 Aligned redirect (REDIRECT_PC[1:0]=0) next state: DRAIN if outstanding (or MEM_VALID not yet seen in WAIT), else REQ if FETCH_EN=1, else IDLE.
REQ-027 DRAIN: MEM_REQ=0; MEM_VALID discarded (INST unchanged), clears outstanding, -> REQ if FETCH_EN else IDLE; further redirect updates pc, stays DRAIN.
REQ-028 Misaligned redirect (REDIRECT_PC[1:0]!=0): EXC_MISALIGN<=1, EXC_PC<=REDIRECT_PC, -> FAULT; outstanding tracking continues.
REQ-029 FAULT: no requests; MEM_VALID discarded; held until a redirect; aligned redirect clears EXC_MISALIGN, exits per REQ-026; misaligned updates EXC_PC, stays FAULT.
REQ-030 REDIRECT and MEM_VALID in same WAIT cycle: response discarded, outstanding cleared, -> REQ/IDLE (not DRAIN).

Reset
REQ-031 RST=0 at a clock edge SHALL force state IDLE, pc=RESET_PC, outstanding=0, MEM_REQ=0, INST_VALID=0, INST=0, INST_PC=0, EXC_MISALIGN=0, EXC_PC=0, from any state.
REQ-032 A MEM_VALID arriving after reset from a pre-reset request SHALL be ignored.

Verification
REQ-033 Reset, FETCH_EN=1, memory 1-cycle latency, INST_READY=1 -> MEM_ADDR 0,4,8 with MEM_REQ every 3rd cycle; INST_PC 0,4,8 matches MEM_DATA.
REQ-034 INST_READY=0 for 5 cycles in HOLD -> INST/INST_PC/INST_VALID unchanged, no MEM_REQ; transfer on READY then MEM_ADDR=pc+4.
REQ-035 REDIRECT_PC=32'h00000100 during WAIT, MEM_VALID 2 cycles later with 32'hDEADBEEF -> DEADBEEF never on INST with INST_VALID=1; next MEM_ADDR=32'h100.
REQ-036 REDIRECT_PC=32'h00000102 -> EXC_MISALIGN=1, EXC_PC=32'h102, no MEM_REQ; later REDIRECT_PC=32'h200 -> EXC_MISALIGN=0, fetch 32'h200.
REQ-037 pc=32'hFFFFFFFC transfer -> next MEM_ADDR=32'h00000000.
REQ-038 RST=0 during WAIT, stale MEM_VALID after reset -> INST_VALID stays 0, MEM_ADDR=RESET_PC.

Source files
------------

// File: rtl/core_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, decode handoff, redirect and fault report.
// master = fetch unit, slave = memory/decode/branch side.
interface core_fetch_if;
    logic        FETCH_EN;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_VALID;
    logic [31:0] MEM_DATA;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        EXC_MISALIGN;
    logic [31:0] EXC_PC;

    modport master (
        input  FETCH_EN, MEM_VALID, MEM_DATA, INST_READY, REDIRECT, REDIRECT_PC,
        output MEM_REQ, MEM_ADDR, INST_VALID, INST, INST_PC, EXC_MISALIGN, EXC_PC
    );

    modport slave (
        output FETCH_EN, MEM_VALID, MEM_DATA, INST_READY, REDIRECT, REDIRECT_PC,
        input  MEM_REQ, MEM_ADDR, INST_VALID, INST, INST_PC, EXC_MISALIGN, EXC_PC
    );
endinterface

// File: rtl/core_fetch.sv
// Single-outstanding instruction fetch: 3 cycles/instruction minimum with 1-cycle memory.
// Decode backpressure holds the instruction in HOLD; redirect flushes, draining any in-flight response.
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    core_fetch_if.master  fetch
);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        REQ   = 6'b000010,
        WAIT  = 6'b000100,
        HOLD  = 6'b001000,
        DRAIN = 6'b010000,
        FAULT = 6'b100000
    } state_t;

    state_t      state;
    state_t      resume_state;
    logic [31:0] pc;
    logic        outstanding;
    logic        resp_now;
    logic        pend_after;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        exc_misalign;
    logic [31:0] exc_pc;

    assign fetch.MEM_REQ      = (state == REQ);
    assign fetch.MEM_ADDR     = pc;
    assign fetch.INST_VALID   = inst_valid;
    assign fetch.INST         = inst;
    assign fetch.INST_PC      = inst_pc;
    assign fetch.EXC_MISALIGN = exc_misalign;
    assign fetch.EXC_PC       = exc_pc;

    // A request issued in REQ counts as in flight even before the flag is set.
    always_comb begin
        resume_state = fetch.FETCH_EN ? REQ : IDLE;
        resp_now     = fetch.MEM_VALID && (state == WAIT || state == DRAIN || state == FAULT);
        pend_after   = (outstanding || state == REQ) && !resp_now;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            outstanding  <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= 32'h0;
            inst_pc      <= 32'h0;
            exc_misalign <= 1'b0;
            exc_pc       <= 32'h0;
        end else if (fetch.REDIRECT) begin
            pc          <= fetch.REDIRECT_PC;
            inst_valid  <= 1'b0;
            outstanding <= pend_after;
            if (fetch.REDIRECT_PC[1:0] != 2'b00) begin
                exc_misalign <= 1'b1;
                exc_pc       <= fetch.REDIRECT_PC;
                state        <= FAULT;
            end else begin
                exc_misalign <= 1'b0;
                state        <= pend_after ? DRAIN : resume_state;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (fetch.FETCH_EN) state <= REQ;
                end
                REQ: begin
                    outstanding <= 1'b1;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (fetch.MEM_VALID) begin
                        inst        <= fetch.MEM_DATA;
                        inst_pc     <= pc;
                        inst_valid  <= 1'b1;
                        outstanding <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_valid && fetch.INST_READY) begin
                        pc         <= pc + 32'd4;
                        inst_valid <= 1'b0;
                        state      <= resume_state;
                    end
                end
                DRAIN: begin
                    // The stale response is dropped; INST keeps its old value.
                    if (fetch.MEM_VALID || !outstanding) begin
                        outstanding <= 1'b0;
                        state       <= resume_state;
                    end
                end
                FAULT: begin
                    if (fetch.MEM_VALID) outstanding <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
